// File: rtl/cpu_trace_probe_pkg.sv
// Shared definitions for the CPU trace probe: mode encodings, channel-ID width
// and the bit layout of a trace entry {timestamp, channel ID, value}.
package trace_pkg;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_CHG = 2'b01;
    localparam logic [1:0] MODE_RR  = 2'b10;
    localparam logic [1:0] MODE_FRZ = 2'b11;

    localparam int unsigned OVF_W       = 8;
    localparam int unsigned ENT_VAL_LSB = 0;

    // Channel ID width; a single channel still carries a 1-bit ID field.
    function automatic int unsigned ch_w(input int unsigned channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    function automatic int unsigned ent_ch_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned ent_ts_lsb(input int unsigned data_w, input int unsigned chw);
        return data_w + chw;
    endfunction

endpackage

// File: rtl/cpu_trace_probe_if.sv
// Trace readout port: valid/ready handshake carrying one trace entry.
interface cpu_trace_probe_if #(
    parameter int unsigned ENT_W = 51
) ();
    logic             rd_valid;
    logic             rd_ready;
    logic [ENT_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/cpu_trace_probe_fifo.sv
// Synchronous show-ahead FIFO with registered head, valid and occupancy level.
// The writer must only assert wr_en_i when there is room or a read happens on the same edge.
module trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 51
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_ready_i,
    output logic                   rd_valid_o,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rd_fire;

    assign rd_fire = valid_q && rd_ready_i;

    // Next head is bypassed from the write port when it lands in the slot being exposed.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        data_d   = data_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
            data_d   = '0;
        end else begin
            if (wr_en_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LVL_W'(wr_en_i) - LVL_W'(rd_fire);
            valid_d = (level_d != '0);
            data_d  = (wr_en_i && (rd_ptr_d == wr_ptr_q)) ? wr_data_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i && !clear_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign rd_valid_o = valid_q;
    assign rd_data_o  = data_q;
    assign level_o    = level_q;

endmodule

// File: rtl/cpu_trace_probe.sv
// CPU trace probe: change-capture or round-robin sampling of watched channels into a
// timestamped trace FIFO, with saturating drop counter.
module cpu_trace_probe
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS*DATA_W-1:0] ch_data,
    input  logic [CHANNELS-1:0]        ch_en,
    input  logic [1:0]                 mode,
    input  logic                       clear,
    cpu_trace_probe_if.master          rd,
    output logic [OVF_W-1:0]           overflow_cnt,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned CH_W   = ch_w(CHANNELS);
    localparam int unsigned ENT_W  = TS_W + CH_W + DATA_W;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned CH_LSB = ent_ch_lsb(DATA_W);
    localparam int unsigned TS_LSB = ent_ts_lsb(DATA_W, CH_W);

    logic [TS_W-1:0]     ts_q;
    logic                primed_q;
    logic [DATA_W-1:0]   shadow_q [CHANNELS];
    logic [DATA_W-1:0]   lat_q    [CHANNELS];
    logic [DATA_W-1:0]   lat_d    [CHANNELS];
    logic [DATA_W-1:0]   ch_arr   [CHANNELS];
    logic [CHANNELS-1:0] pending_q, pending_d, chg;
    logic [CH_W-1:0]     rr_q, rr_d, rr_idx, sel_ch;
    logic [DATA_W-1:0]   sel_val;
    logic                sel_vld, can_wr, wr_en, drop, rd_fire, fifo_valid;
    logic [ENT_W-1:0]    wr_data, fifo_data;
    logic [OVF_W-1:0]    ovf_q, ovf_d;
    logic [LVL_W-1:0]    fifo_level;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
            chg[i]    = primed_q && (mode == MODE_CHG) && ch_en[i] && (ch_arr[i] != shadow_q[i]);
        end
    end

    // Writer source: lowest pending channel, or next enabled channel at/after rr.
    always_comb begin
        sel_vld = 1'b0;
        sel_ch  = '0;
        sel_val = '0;
        rr_idx  = '0;
        rr_d    = rr_q;
        case (mode)
            MODE_CHG: begin
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    if (pending_q[i]) begin
                        sel_vld = 1'b1;
                        sel_ch  = CH_W'(i);
                    end
                end
                sel_val = lat_q[sel_ch];
            end
            MODE_RR: begin
                for (int k = CHANNELS - 1; k >= 0; k--) begin
                    rr_idx = CH_W'((32'(rr_q) + 32'(k)) % CHANNELS);
                    if (ch_en[rr_idx]) begin
                        sel_vld = 1'b1;
                        sel_ch  = rr_idx;
                    end
                end
                sel_val = ch_arr[sel_ch];
                if (sel_vld) rr_d = (sel_ch == CH_W'(CHANNELS - 1)) ? '0 : sel_ch + CH_W'(1);
            end
            default: ;
        endcase
    end

    assign rd_fire = fifo_valid && rd.rd_ready;
    assign can_wr  = (fifo_level < LVL_W'(DEPTH)) || rd_fire;
    assign wr_en   = sel_vld && can_wr && !clear;
    assign drop    = sel_vld && !can_wr && !clear;

    always_comb begin
        wr_data = '0;
        wr_data[TS_LSB +: TS_W]        = ts_q;
        wr_data[CH_LSB +: CH_W]        = sel_ch;
        wr_data[ENT_VAL_LSB +: DATA_W] = sel_val;
    end

    // A change on the channel being drained keeps it pending with the fresh value.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < CHANNELS; i++) lat_d[i] = chg[i] ? ch_arr[i] : lat_q[i];
        case (mode)
            MODE_OFF: pending_d = '0;
            MODE_CHG: begin
                if (sel_vld) pending_d[sel_ch] = 1'b0;
                pending_d = pending_d | chg;
            end
            default: ;
        endcase
        if (clear) pending_d = '0;

        ovf_d = ovf_q;
        if (clear)                             ovf_d = '0;
        else if (drop && (ovf_q != '1))        ovf_d = ovf_q + OVF_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q      <= '0;
            primed_q  <= 1'b0;
            pending_q <= '0;
            rr_q      <= '0;
            ovf_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                lat_q[i]    <= '0;
            end
        end else begin
            ts_q      <= ts_q + TS_W'(1);
            primed_q  <= 1'b1;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= ch_arr[i];
                lat_q[i]    <= lat_d[i];
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (clear),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_ready_i (rd.rd_ready),
        .rd_valid_o (fifo_valid),
        .rd_data_o  (fifo_data),
        .level_o    (fifo_level)
    );

    assign rd.rd_valid   = fifo_valid;
    assign rd.rd_data    = fifo_data;
    assign overflow_cnt  = ovf_q;
    assign level         = fifo_level;

endmodule

// File: tb/tb_cpu_trace_probe.sv
// Bench for cpu_trace_probe: directed table and sequences plus randomized traffic
// against a queue-based reference model of the trace rules.
module tb_cpu_trace_probe;
    import trace_pkg::*;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CHANNELS = 6;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned TS_W     = 16;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned ENT_W    = TS_W + CH_W + DATA_W;
    localparam int unsigned LVL_W    = 5;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [CHANNELS*DATA_W-1:0] ch_data;
    logic [CHANNELS-1:0]        ch_en;
    logic [1:0]                 mode;
    logic                       clear;
    logic [7:0]                 overflow_cnt;
    logic [LVL_W-1:0]           level;

    cpu_trace_probe_if #(.ENT_W(ENT_W)) rd_if ();

    cpu_trace_probe #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_data      (ch_data),
        .ch_en        (ch_en),
        .mode         (mode),
        .clear        (clear),
        .rd           (rd_if),
        .overflow_cnt (overflow_cnt),
        .level        (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model state
    int               m_ts;
    bit               m_primed;
    logic [DATA_W-1:0] m_shadow [CHANNELS];
    logic [DATA_W-1:0] m_lat    [CHANNELS];
    bit               m_pend   [CHANNELS];
    int               m_rr;
    int               m_ovf;
    logic [ENT_W-1:0] m_q [$];

    typedef struct {
        logic [DATA_W-1:0] ch2;
        bit                rdy;
        bit                ev;
        int                el;
        logic [ENT_W-1:0]  ed;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mkv(logic [DATA_W-1:0] ch2, bit rdy, bit ev, int el, logic [ENT_W-1:0] ed);
        vec_t v;
        v.ch2 = ch2; v.rdy = rdy; v.ev = ev; v.el = el; v.ed = ed;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] chv(int i);
        return ch_data[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [ENT_W-1:0] mk(int ts, int ch, logic [DATA_W-1:0] v);
        logic [TS_W-1:0] t = TS_W'(ts);
        logic [CH_W-1:0] c = CH_W'(ch);
        return {t, c, v};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        m_ts = 0; m_primed = 0; m_rr = 0; m_ovf = 0;
        m_q.delete();
        for (int i = 0; i < CHANNELS; i++) begin
            m_shadow[i] = '0; m_lat[i] = '0; m_pend[i] = 0;
        end
    endtask

    // Apply one clock edge's worth of trace rules to the model using current inputs.
    task automatic model_edge();
        bit rd, have;
        logic [ENT_W-1:0] e;
        bit chg [CHANNELS];
        rd = (m_q.size() > 0) && (rd_if.rd_ready == 1'b1);
        have = 0;
        e = '0;
        for (int i = 0; i < CHANNELS; i++)
            chg[i] = m_primed && (mode == MODE_CHG) && ch_en[i] && (chv(i) != m_shadow[i]);
        if (mode == MODE_CHG) begin
            for (int i = 0; i < CHANNELS && !have; i++)
                if (m_pend[i]) begin
                    have = 1; e = mk(m_ts, i, m_lat[i]); m_pend[i] = 0;
                end
        end else if (mode == MODE_RR) begin
            for (int k = 0; k < CHANNELS && !have; k++) begin
                int j;
                j = (m_rr + k) % CHANNELS;
                if (ch_en[j]) begin
                    have = 1; e = mk(m_ts, j, chv(j)); m_rr = (j + 1) % CHANNELS;
                end
            end
        end
        for (int i = 0; i < CHANNELS; i++)
            if (chg[i]) begin m_pend[i] = 1; m_lat[i] = chv(i); end
        if (mode == MODE_OFF)
            for (int i = 0; i < CHANNELS; i++) m_pend[i] = 0;
        if (clear) begin
            m_q.delete(); m_ovf = 0;
            for (int i = 0; i < CHANNELS; i++) m_pend[i] = 0;
        end else begin
            if (rd) void'(m_q.pop_front());
            if (have) begin
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else if (m_ovf < 255) m_ovf++;
            end
        end
        for (int i = 0; i < CHANNELS; i++) m_shadow[i] = chv(i);
        m_primed = 1;
        m_ts++;
    endtask

    task automatic compare_model();
        check("model_valid", 64'(rd_if.rd_valid), 64'(m_q.size() > 0));
        check("model_level", 64'(level), 64'(m_q.size()));
        check("model_ovf", 64'(overflow_cnt), 64'(m_ovf));
        if (m_q.size() > 0) check("model_data", 64'(rd_if.rd_data), 64'(m_q[0]));
    endtask

    task automatic tick();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        edge_no++;
        compare_model();
    endtask

    task automatic reset_pulse(string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check({tag, "_valid"}, 64'(rd_if.rd_valid), 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_cnt), 64'd0);
        check({tag, "_data"}, 64'(rd_if.rd_data), 64'd0);
        #1;
        reset = 1'b1;
        edge_no = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_pulse("reset");
    endtask

    task automatic bump(int ch);
        ch_data[ch*DATA_W +: DATA_W] = chv(ch) ^ ($urandom | 32'h1);
    endtask

    initial begin
        logic [ENT_W-1:0] h;
        int ids3 [3];
        int ids4 [4];
        int chg_edge;
        int r;

        reset = 1'b0; ch_data = '0; ch_en = '0; mode = MODE_OFF; clear = 1'b0;
        rd_if.rd_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Constant inputs (nonzero before priming) must produce nothing.
        do_reset();
        mode = MODE_CHG; ch_en = '1;
        for (int i = 0; i < CHANNELS; i++) ch_data[i*DATA_W +: DATA_W] = $urandom | 32'h1;
        repeat (10) tick();
        check("const_valid", 64'(rd_if.rd_valid), 64'd0);
        check("const_level", 64'(level), 64'd0);
        check("const_ovf", 64'(overflow_cnt), 64'd0);

        // Single change on channel 2 at edge 5: two-edge latency, timestamp 6.
        do_reset();
        ch_data = '0;
        tbl[0] = mkv(32'h0,    0, 0, 0, '0);
        tbl[1] = mkv(32'h0,    0, 0, 0, '0);
        tbl[2] = mkv(32'h0,    0, 0, 0, '0);
        tbl[3] = mkv(32'h0,    0, 0, 0, '0);
        tbl[4] = mkv(32'h0,    0, 0, 0, '0);
        tbl[5] = mkv(32'h1234, 0, 0, 0, '0);
        tbl[6] = mkv(32'h1234, 0, 1, 1, {16'd6, 3'd2, 32'h0000_1234});
        tbl[7] = mkv(32'h1234, 1, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            ch_data[2*DATA_W +: DATA_W] = tbl[i].ch2;
            rd_if.rd_ready = tbl[i].rdy;
            tick();
            check("tbl_valid", 64'(rd_if.rd_valid), 64'(tbl[i].ev));
            check("tbl_level", 64'(level), 64'(tbl[i].el));
            if (tbl[i].ev) check("tbl_data", 64'(rd_if.rd_data), 64'(tbl[i].ed));
        end

        // Channels 0,3,5 change together: drained in index order, consecutive timestamps.
        rd_if.rd_ready = 1'b0;
        chg_edge = edge_no;
        bump(0); bump(3); bump(5);
        repeat (4) tick();
        check("multi_level", 64'(level), 64'd3);
        ids3 = '{0, 3, 5};
        rd_if.rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            h = rd_if.rd_data;
            check("multi_id", 64'(h[DATA_W +: CH_W]), 64'(ids3[k]));
            check("multi_ts", 64'(h[DATA_W+CH_W +: TS_W]), 64'(chg_edge + 1 + k));
            tick();
        end
        check("multi_drained", 64'(level), 64'd0);

        // Round-robin over 0,2,5 until full, then drops and saturation.
        do_reset();
        mode = MODE_RR; ch_en = 6'b100101; rd_if.rd_ready = 1'b0;
        repeat (16) tick();
        check("rr_full", 64'(level), 64'd16);
        check("rr_nodrop", 64'(overflow_cnt), 64'd0);
        repeat (3) tick();
        check("rr_drop3", 64'(overflow_cnt), 64'd3);
        ids3 = '{0, 2, 5};
        rd_if.rd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            h = rd_if.rd_data;
            check("rr_id", 64'(h[DATA_W +: CH_W]), 64'(ids3[k % 3]));
            tick();
        end
        check("rr_full_rw_level", 64'(level), 64'd16);
        check("rr_full_rw_ovf", 64'(overflow_cnt), 64'd3);
        rd_if.rd_ready = 1'b0;
        repeat (260) tick();
        check("rr_sat", 64'(overflow_cnt), 64'd255);

        // Freeze holds four pending changes; resuming drains them in index order.
        do_reset();
        mode = MODE_CHG; ch_en = '1; ch_data = '0; rd_if.rd_ready = 1'b0;
        repeat (2) tick();
        bump(1); bump(2); bump(4); bump(5);
        tick();
        mode = MODE_FRZ;
        repeat (3) tick();
        check("frz_level", 64'(level), 64'd0);
        mode = MODE_CHG;
        repeat (4) tick();
        check("frz_resume_level", 64'(level), 64'd4);
        ids4 = '{1, 2, 4, 5};
        rd_if.rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            h = rd_if.rd_data;
            check("frz_id", 64'(h[DATA_W +: CH_W]), 64'(ids4[k]));
            tick();
        end

        // Clear mid-burst at level 7.
        do_reset();
        mode = MODE_RR; ch_en = '1; rd_if.rd_ready = 1'b0;
        repeat (7) tick();
        check("clr_pre_level", 64'(level), 64'd7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_level", 64'(level), 64'd0);
        check("clr_valid", 64'(rd_if.rd_valid), 64'd0);

        // Async reset mid-burst, then priming suppresses the first differing sample.
        repeat (7) tick();
        check("arst_pre_level", 64'(level), 64'd7);
        #1;
        mode = MODE_CHG;
        for (int i = 0; i < CHANNELS; i++) ch_data[i*DATA_W +: DATA_W] = $urandom | 32'h1;
        reset_pulse("arst");
        repeat (3) tick();
        check("prime_level", 64'(level), 64'd0);
        bump(4);
        repeat (2) tick();
        check("prime_after", 64'(level), 64'd1);

        // Randomized traffic against the model.
        do_reset();
        ch_data = '0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 16 == 0) begin
                r = int'($urandom_range(0, 9));
                mode = (r < 6) ? MODE_CHG : (r < 8) ? MODE_RR : (r < 9) ? MODE_FRZ : MODE_OFF;
            end
            if (n % 40 == 0) ch_en = CHANNELS'($urandom);
            for (int i = 0; i < CHANNELS; i++)
                if ($urandom_range(0, 3) == 0) ch_data[i*DATA_W +: DATA_W] = $urandom;
            rd_if.rd_ready = ($urandom_range(0, 3) < (((n / 100) % 2 == 1) ? 1 : 3));
            clear = ($urandom_range(0, 79) == 0);
            tick();
        end
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_trace_probe.md
# cpu_trace_probe

Synthesizable, parametrised trace probe that watches up to CHANNELS 32-bit CPU signals (PC, register-file taps) and logs value changes or periodic samples into an on-chip FIFO. Each entry carries a timestamp and channel ID, and is read out through a valid/ready port. It sits beside `CPU` in simulation and FPGA builds. It replaces ad-hoc hierarchical probe wires with a reusable, bounded-latency trace path.

## Interface
- DATA_W, 32, width of each watched channel
- CHANNELS, 6, number of watched channels (1..16)
- DEPTH, 16, trace FIFO entries (power of 2, ≥2)
- TS_W, 16, timestamp width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ch_data  in  CHANNELS*DATA_W  packed channel values; channel i at [i*DATA_W +: DATA_W]
- ch_en  in  CHANNELS  per-channel enable mask
- mode  in  2  00 off, 01 change-capture, 10 round-robin sample, 11 freeze
- clear  in  1  synchronous flush of FIFO, pending bits and overflow count
- rd_valid  out  1  FIFO head entry available
- rd_ready  in  1  consumer accepts head entry
- rd_data  out  TS_W+CH_W+DATA_W  {timestamp, channel ID, value}; CH_W = max(1, clog2(CHANNELS))
- overflow_cnt  out  8  dropped-entry count, saturating at 255
- level  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Timestamp counter: free-running, +1 per clk, wraps modulo 2^TS_W. It is 0 in the first cycle after reset deassertion.
- Shadow register per channel samples ch_data every cycle in all modes.
- `primed` flag: cleared by reset and set at the first edge after reset. No change is detected until primed=1.
- Change detect (mode 01): on an edge where primed=1, ch_en[i]=1 and ch_data[i] != shadow[i], set pending[i] and latch lat[i] <= ch_data[i].
- Writer: each cycle it selects the lowest-index set pending bit. It writes {ts, i, lat[i]} and clears pending[i], unless a new change of i occurs on the same edge, in which case pending[i] stays set and lat[i] takes the new value. At most one write per cycle.
- Mode 10: pointer rr walks enabled channels in ascending order with wrap. Each cycle it writes {ts, rr, ch_data[rr]}. Pending bits are ignored.
- Mode 00: no writes; pending cleared. Mode 11: no writes; pending held; readout continues.
- Write permitted when level < DEPTH, or when a read happens on the same edge. Otherwise the selected entry is dropped, its pending bit cleared, and overflow_cnt incremented (saturating).
- ch_en all zero in mode 10: no writes.
- clear: level→0, pending→0, overflow_cnt→0. It has priority over a simultaneous write and read. Timestamp is not cleared.

## Timing
- Reset values: rd_valid 0, rd_data 0, overflow_cnt 0, level 0; pending, shadow, lat, rr and primed all 0.
- Change on ch_data presented before edge N is registered as pending at N and written to the FIFO at N+1. rd_valid rises after N+1, a latency of 2 edges. Entry timestamp = ts value at edge N+1.
- A read completes on an edge where rd_valid && rd_ready. The next entry (if any) appears on rd_data the same cycle after that edge, with no bubble.
- Simultaneous read+write at level=DEPTH: both succeed; level unchanged.
- FIFO pointers wrap modulo DEPTH.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and entries are discarded.

## Structure
- Shared package `trace_pkg`:
  - mode encodings: MODE_OFF, MODE_CHG, MODE_RR, MODE_FRZ
  - CH_W function
  - entry-field offset constants
- One sub-module, `trace_fifo`: parametrised synchronous FIFO (DEPTH, width) with level output and show-ahead head. The probe holds detect, arbitration, timestamp and overflow logic.

## Test plan
- Reset, mode 01, hold ch_data constant for 10 cycles → rd_valid stays 0, level 0, overflow_cnt 0.
- Mode 01, channel 2 changes 0→0x1234 at edge 5 → an entry with value 0x1234, channel 2 and timestamp 6 appears after edge 6 (2-edge latency). Read with rd_ready=1 → level returns to 0.
- Channels 0, 3 and 5 change on the same edge → three entries in order 0, 3, 5 with consecutive timestamps.
- Mode 10, CHANNELS=6, ch_en=6'b100101, rd_ready=0 → entries for channels 0, 2, 5, 0… until level=16. Every further cycle increments overflow_cnt, which saturates at 255. Assert rd_ready at full → level stays 16 with no new drops.
- Mode 11 with 4 pending changes → no writes. Switch to 01 → 4 entries appear in index order.
- clear or async reset mid-burst at level=7 → level 0 and rd_valid 0 on the next cycle. After reset, the first changed sample is not logged until primed.
